// File: rtl/obj_row_fetch_pkg.sv
// rtl/obj_row_fetch_pkg.sv - shared graphics obj types, step constants and helpers
package obj_row_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

    // Pixels covered by one VRAM halfword in each colour depth
    localparam int STEP_8BPP = 1;
    localparam int STEP_4BPP = 2;

    // Row pitch of the 2D tile map in pixels
    localparam int STRIDE_2D = 128;

    // Position of the highest set bit; 0 when no bit is set
    function automatic logic [3:0] msb_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/obj_addr_calc.sv
// rtl/obj_addr_calc.sv - combinational VRAM halfword address for one sprite fetch
module obj_addr_calc
    import obj_row_fetch_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int XW     = 6
) (
    input  logic [9:0]        objname_i,
    input  logic [2:0]        bgmode_i,
    input  logic              palettemode_i,
    input  logic              oam_mode_i,
    input  logic [XW:0]       hsize_i,
    input  logic [XW-1:0]     x_i,
    input  logic [XW-1:0]     y_i,
    output logic [ADDR_W-1:0] addr_o
);

    // Sum is formed three bits wider than the address, then wraps on truncation
    localparam int SW = ADDR_W + 3;

    logic [14:0]   offset;
    logic [XW-1:0] adj_x;
    logic [15:0]   stride;
    logic [3:0]    shift;

    // Bitmap modes push the tile base into the upper VRAM half
    assign offset = {objname_i[9] | (bgmode_i != 3'd0) | (bgmode_i[1] & bgmode_i[0]),
                     objname_i[8:1],
                     objname_i[0] & (~palettemode_i | oam_mode_i),
                     5'b0};

    // In 4bpp two pixels share a halfword
    assign adj_x  = palettemode_i ? x_i : (x_i >> 1);
    assign stride = oam_mode_i ? 16'(hsize_i) : 16'(STRIDE_2D);
    assign shift  = msb_index(stride);

    assign addr_o = ADDR_W'(SW'(offset) + SW'(adj_x) + (SW'(y_i) << shift));

endmodule

// File: rtl/obj_row_fetch.sv
// rtl/obj_row_fetch.sv - fetches one sprite row from VRAM as a stream of halfwords
module obj_row_fetch
    import obj_row_fetch_pkg::*;
#(
    parameter int MAX_HSIZE = 64,
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [9:0]                    objname,
    input  logic [2:0]                    bgmode,
    input  logic                          palettemode,
    input  logic                          oam_mode,
    input  logic                          hflip,
    input  logic [$clog2(MAX_HSIZE):0]    hsize,
    input  logic [$clog2(MAX_HSIZE)-1:0]  y,
    output logic                          vram_req,
    output logic [ADDR_W-1:0]             vram_addr,
    input  logic                          vram_ack,
    input  logic [DATA_W-1:0]             vram_rdata,
    output logic                          pix_valid,
    output logic [DATA_W-1:0]             pix_data,
    output logic [$clog2(MAX_HSIZE)-1:0]  pix_x,
    output logic                          busy,
    output logic                          done
);

    localparam int XW = $clog2(MAX_HSIZE);

    fetch_state_e state_q, state_d;

    logic [9:0]        objname_q;
    logic [2:0]        bgmode_q;
    logic              pal_q, oam_q, hflip_q;
    logic [XW:0]       hsize_q;
    logic [XW-1:0]     y_q;

    logic [XW-1:0]     x_q, x_d;
    logic [XW:0]       remain_q, remain_d;
    logic              pix_valid_q, pix_valid_d;
    logic [DATA_W-1:0] pix_data_q, pix_data_d;
    logic [XW-1:0]     pix_x_q, pix_x_d;

    logic              launch;
    logic              accept;
    logic [XW:0]       start_step;
    logic [XW:0]       start_count;
    logic [XW-1:0]     row_step;
    logic [ADDR_W-1:0] calc_addr;

    // Abort outranks both a new start and an ack in flight
    assign launch      = (state_q == ST_IDLE) && start && !abort;
    assign accept      = (state_q == ST_REQ) && vram_ack && !abort;
    assign start_step  = palettemode ? (XW+1)'(STEP_8BPP) : (XW+1)'(STEP_4BPP);
    assign start_count = palettemode ? hsize : (hsize >> 1);
    assign row_step    = pal_q ? XW'(STEP_8BPP) : XW'(STEP_4BPP);

    obj_addr_calc #(
        .ADDR_W (ADDR_W),
        .XW     (XW)
    ) u_addr_calc (
        .objname_i     (objname_q),
        .bgmode_i      (bgmode_q),
        .palettemode_i (pal_q),
        .oam_mode_i    (oam_q),
        .hsize_i       (hsize_q),
        .x_i           (x_q),
        .y_i           (y_q),
        .addr_o        (calc_addr)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state: a row with no halfwords goes straight to DONE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (launch) state_d = (start_count == '0) ? ST_DONE : ST_REQ;
            ST_REQ: begin
                if (abort)                                         state_d = ST_IDLE;
                else if (accept && remain_q == (XW+1)'(1))         state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; address reads zero whenever no request is open
    always_comb begin
        vram_req  = (state_q == ST_REQ);
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        vram_addr = vram_req ? calc_addr : '0;
    end

    // Row config is captured only when a row is launched, so mid-row starts cannot disturb it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            objname_q <= '0;
            bgmode_q  <= '0;
            pal_q     <= 1'b0;
            oam_q     <= 1'b0;
            hflip_q   <= 1'b0;
            hsize_q   <= '0;
            y_q       <= '0;
        end else if (launch) begin
            objname_q <= objname;
            bgmode_q  <= bgmode;
            pal_q     <= palettemode;
            oam_q     <= oam_mode;
            hflip_q   <= hflip;
            hsize_q   <= hsize;
            y_q       <= y;
        end
    end

    // Walk x and the remaining-request count; capture read data on each accepted ack
    always_comb begin
        x_d         = x_q;
        remain_d    = remain_q;
        pix_valid_d = 1'b0;
        pix_data_d  = pix_data_q;
        pix_x_d     = pix_x_q;
        if (launch) begin
            x_d      = hflip ? XW'(hsize - start_step) : '0;
            remain_d = start_count;
        end else if (accept) begin
            pix_valid_d = 1'b1;
            pix_data_d  = vram_rdata;
            pix_x_d     = x_q;
            x_d         = hflip_q ? (x_q - row_step) : (x_q + row_step);
            remain_d    = remain_q - (XW+1)'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_q         <= '0;
            remain_q    <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            pix_x_q     <= '0;
        end else begin
            x_q         <= x_d;
            remain_q    <= remain_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            pix_x_q     <= pix_x_d;
        end
    end

    assign pix_valid = pix_valid_q;
    assign pix_data  = pix_data_q;
    assign pix_x     = pix_x_q;

endmodule

// File: tb/tb_obj_row_fetch.sv
// tb/tb_obj_row_fetch.sv - self-checking bench for obj_row_fetch
module tb_obj_row_fetch;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start, abort;
    logic [9:0]  objname;
    logic [2:0]  bgmode;
    logic        palettemode, oam_mode, hflip;
    logic [6:0]  hsize;
    logic [5:0]  y;
    logic        vram_req;
    logic [14:0] vram_addr;
    logic        vram_ack;
    logic [15:0] vram_rdata;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic [5:0]  pix_x;
    logic        busy, done;

    always #5 clock = ~clock;

    obj_row_fetch #(.MAX_HSIZE(64), .ADDR_W(15), .DATA_W(16)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .objname     (objname),
        .bgmode      (bgmode),
        .palettemode (palettemode),
        .oam_mode    (oam_mode),
        .hflip       (hflip),
        .hsize       (hsize),
        .y           (y),
        .vram_req    (vram_req),
        .vram_addr   (vram_addr),
        .vram_ack    (vram_ack),
        .vram_rdata  (vram_rdata),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .busy        (busy),
        .done        (done)
    );

    typedef struct packed {
        logic [9:0]       objname;
        logic [2:0]       bgmode;
        logic             pal;
        logic             oam;
        logic             hflip;
        logic [6:0]       hsize;
        logic [5:0]       y;
        logic [3:0][14:0] addr;
        logic [3:0][5:0]  xs;
    } vec_t;

    typedef struct packed {
        logic [15:0] d;
        logic [5:0]  x;
    } pix_t;

    vec_t vecs [7];
    pix_t exp_q [$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    function automatic vec_t mk(input int on, input int bg, input int pal, input int oam,
                                input int hf, input int hs, input int yy,
                                input int a0, input int a1, input int a2, input int a3,
                                input int x0, input int x1, input int x2, input int x3);
        vec_t v;
        v.objname = 10'(on);  v.bgmode = 3'(bg);
        v.pal = 1'(pal);      v.oam = 1'(oam);   v.hflip = 1'(hf);
        v.hsize = 7'(hs);     v.y = 6'(yy);
        v.addr[0] = 15'(a0);  v.addr[1] = 15'(a1); v.addr[2] = 15'(a2); v.addr[3] = 15'(a3);
        v.xs[0] = 6'(x0);     v.xs[1] = 6'(x1);    v.xs[2] = 6'(x2);    v.xs[3] = 6'(x3);
        return v;
    endfunction

    task automatic apply_cfg(input vec_t v);
        objname = v.objname; bgmode = v.bgmode; palettemode = v.pal;
        oam_mode = v.oam; hflip = v.hflip; hsize = v.hsize; y = v.y;
    endtask

    task automatic pop_pix(input string tag);
        pix_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected_pix"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_pix_data"}, pix_data, e.d);
            check({tag, "_pix_x"}, pix_x, e.x);
        end
    endtask

    // Called just after a negedge; launches a row and services it until done or abort
    task automatic run_row(input string tag, input vec_t v, input int stall_k, input int abort_k,
                           input bit mid_start, output int pix_cnt, output int done_cyc);
        int k, stalls;
        bit fin;
        pix_t p;
        k = 0; stalls = 0; fin = 0; pix_cnt = 0; done_cyc = 0;
        apply_cfg(v);
        start = 1'b1;
        for (int c = 1; c <= 40 && !fin; c++) begin
            @(negedge clock);
            start = 1'b0; abort = 1'b0; vram_ack = 1'b0;
            if (pix_valid) begin
                pix_cnt++;
                pop_pix(tag);
            end
            if (done) begin
                done_cyc = c;
                check({tag, "_done_with_pix"}, pix_valid, 1);
                fin = 1;
            end else if (vram_req) begin
                if (k > 3) begin
                    check({tag, "_extra_req"}, 1, 0);
                    fin = 1;
                end else begin
                    check($sformatf("%s_addr%0d", tag, k), vram_addr, v.addr[k]);
                    if (k == abort_k) begin
                        abort = 1'b1; vram_ack = 1'b1; vram_rdata = 16'($urandom);
                        fin = 1;
                    end else if (k == stall_k && stalls < 3) begin
                        stalls++;
                        if (mid_start) begin
                            start = 1'b1; objname = 10'd0; hflip = ~v.hflip; hsize = 7'd0;
                        end
                    end else begin
                        vram_ack = 1'b1;
                        vram_rdata = 16'($urandom);
                        p.d = vram_rdata; p.x = v.xs[k];
                        exp_q.push_back(p);
                        k++;
                    end
                end
            end
        end
        if (!fin) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int pc, dc;

        vecs[0] = mk(4, 0, 0, 1, 0, 8, 1, 136, 137, 138, 139, 0, 2, 4, 6);
        vecs[1] = mk(4, 0, 0, 1, 1, 8, 1, 139, 138, 137, 136, 6, 4, 2, 0);
        vecs[2] = mk(4, 0, 1, 1, 0, 4, 2, 136, 137, 138, 139, 0, 1, 2, 3);
        vecs[3] = mk(4, 0, 0, 0, 0, 8, 1, 256, 257, 258, 259, 0, 2, 4, 6);
        vecs[4] = mk(4, 3, 0, 0, 0, 8, 1, 16640, 16641, 16642, 16643, 0, 2, 4, 6);
        vecs[5] = mk(5, 0, 0, 1, 0, 8, 1, 168, 169, 170, 171, 0, 2, 4, 6);
        vecs[6] = mk(3, 0, 1, 0, 1, 4, 0, 67, 66, 65, 64, 3, 2, 1, 0);

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; vram_ack = 1'b0; vram_rdata = '0;
        apply_cfg(vecs[0]);
        repeat (2) @(negedge clock);
        check("rst_vram_req", vram_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_vram_addr", vram_addr, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_busy", busy, 0);

        for (int i = 0; i < 7; i++) begin
            run_row($sformatf("v%0d", i), vecs[i], -1, -1, 0, pc, dc);
            check($sformatf("v%0d_pix_count", i), pc, 4);
            check($sformatf("v%0d_done_cycle", i), dc, 5);
            check($sformatf("v%0d_queue_empty", i), exp_q.size(), 0);
            @(negedge clock);
            check($sformatf("v%0d_idle_after", i), busy, 0);
        end

        // Second request stalled three cycles while a stray start is pulsed
        run_row("stall", vecs[0], 1, -1, 1, pc, dc);
        check("stall_pix_count", pc, 4);
        check("stall_done_cycle", dc, 8);
        check("stall_queue_empty", exp_q.size(), 0);
        @(negedge clock);

        // Abort with a coincident ack on the third request
        run_row("abort", vecs[0], -1, 2, 0, pc, dc);
        check("abort_pix_count", pc, 2);
        @(negedge clock);
        abort = 1'b0; vram_ack = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_vram_req", vram_req, 0);
        check("abort_pix_dropped", pix_valid, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("abort_no_done%0d", i), {30'd0, done, pix_valid}, 0);
        end
        exp_q.delete();

        // Abort and start together in idle
        apply_cfg(vecs[0]); start = 1'b1; abort = 1'b1;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        check("abst_busy", busy, 0);
        check("abst_vram_req", vram_req, 0);
        @(negedge clock);
        check("abst_done", done, 0);

        // Zero-width row
        apply_cfg(vecs[0]); hsize = 7'd0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("h0_done", done, 1);
        check("h0_vram_req", vram_req, 0);
        check("h0_busy", busy, 1);
        @(negedge clock);
        check("h0_done_cleared", done, 0);
        check("h0_idle", busy, 0);

        // Reset mid-row
        apply_cfg(vecs[0]); start = 1'b1;
        @(negedge clock);
        start = 1'b0; vram_ack = 1'b1; vram_rdata = 16'h1234;
        @(negedge clock);
        vram_rdata = 16'hBEEF;
        @(negedge clock);
        vram_ack = 1'b0;
        check("mid_pix_valid_before_rst", pix_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mrst_vram_req", vram_req, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_pix_valid", pix_valid, 0);
        check("mrst_vram_addr", vram_addr, 0);
        check("mrst_pix_data", pix_data, 0);
        check("mrst_pix_x", pix_x, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("mrst_idle_busy", busy, 0);
        check("mrst_idle_req", vram_req, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/obj_row_fetch.md
OBJ_ROW_FETCH -- requirements
Module: obj_row_fetch

Interface
REQ-001 Parameter MAX_HSIZE, default 64: largest supported sprite width in pixels (power of two, 8..128).
REQ-002 Parameter ADDR_W, default 15: VRAM halfword address width.
REQ-003 Parameter DATA_W, default 16: VRAM read data width.
REQ-004 clock  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse; begin fetching one sprite row.
REQ-007 abort  input  1  synchronous cancel of the current row.
REQ-008 objname  input  10  base tile number.
REQ-009 bgmode  input  3  display mode.
REQ-010 palettemode  input  1  1 = 8bpp, 0 = 4bpp.
REQ-011 oam_mode  input  1  1 = 1D mapping, 0 = 2D mapping.
REQ-012 hflip  input  1  reverse horizontal fetch order.
REQ-013 hsize  input  $clog2(MAX_HSIZE)+1  sprite width in pixels.
REQ-014 y  input  $clog2(MAX_HSIZE)  sprite-local row.
REQ-015 vram_req / vram_addr  output  1 / ADDR_W  read request and address.
REQ-016 vram_ack / vram_rdata  input  1 / DATA_W  grant; data valid in the ack cycle.
REQ-017 pix_valid / pix_data / pix_x  output  1 / DATA_W / $clog2(MAX_HSIZE)  fetched halfword and its start x.
REQ-018 busy / done  output  1 / 1  row in progress; one-cycle completion pulse.

Function
REQ-019 FSM states IDLE, REQ, DONE; reset state IDLE.
REQ-020 IDLE: start=1 latches all config inputs -> REQ, or -> DONE if hsize=0, with no request issued.
REQ-021 start outside IDLE is ignored; latched config is not altered mid-row.
REQ-022 Step = 1 pixel when palettemode=1, 2 pixels when palettemode=0; request count = hsize/step, truncated.
REQ-023 x sequence: 0, step, ... ascending; with hflip, descending from hsize-step to 0.
REQ-024 offset = {objname[9]|(bgmode!=0)|(bgmode[1]&bgmode[0]), objname[8:1], objname[0]&(~palettemode|oam_mode), 5'b0}.
REQ-025 adj_x = x when palettemode=1, else x>>1.
REQ-026 stride = hsize when oam_mode=1, else 128; shift = index of highest set stride bit (0 if stride=0).
REQ-027 vram_addr = offset + adj_x + (y << shift), computed at ADDR_W+3 bits, truncated to ADDR_W (wraps).
REQ-028 REQ: vram_req=1; vram_addr stable until vram_ack; no address change without ack.
REQ-029 Ack cycle: register vram_rdata to pix_data and current x to pix_x; pix_valid=1 the next cycle for exactly one cycle.
REQ-030 Ack on the last x -> DONE; otherwise advance x and remain in REQ (back-to-back acks give one request per cycle).
REQ-031 DONE: done=1 for one cycle -> IDLE; the last pix_valid coincides with done.
REQ-032 busy=1 in REQ and DONE.
REQ-033 abort in any state -> IDLE next cycle; no done pulse; abort has priority over ack; data from an ack coincident with abort is dropped.
REQ-034 abort and start in the same IDLE cycle: abort wins; no row starts.

Reset
REQ-035 reset_n=0 asynchronously forces IDLE; vram_req, pix_valid, busy and done = 0; vram_addr, pix_data and pix_x = 0.
REQ-036 Reset mid-row discards all progress; the first cycle after release is idle.

Structure
REQ-037 State enum, step constants and the 128-pixel 2D stride live in the shared graphics obj package.
REQ-038 Address arithmetic is one combinational sub-module, obj_addr_calc, parametrised by ADDR_W and x width; the FSM stays in obj_row_fetch.

Verification
REQ-039 objname=4, bgmode=0, 4bpp, 1D, hsize=8, y=1, ack always high -> addresses 136,137,138,139 on consecutive cycles; done on the 5th cycle after REQ entry.
REQ-040 Same as REQ-039 with hflip=1 -> 139,138,137,136; pix_x sequence 6,4,2,0.
REQ-041 objname=4, 8bpp, 1D, hsize=4, y=2 -> addresses 136..139; 2D, 4bpp, hsize=8, y=1 -> 256..259; bgmode=3 adds 16384.
REQ-042 Ack held low for 3 cycles on the second request -> vram_addr held at 137 throughout; exactly 4 pix_valid pulses.
REQ-043 abort during the third request -> IDLE next cycle; no done; only 2 pix_valid pulses; reset_n low mid-row -> all outputs 0 immediately.
REQ-044 hsize=0 start -> no vram_req; done pulse one cycle after start.
